// File: rtl/uart_status_rd_bridge_if.sv
// Read handshake between the UART command engine and the status readback bridge.
// master = UART side (drives the request toggle and address), slave = bridge.
interface uart_status_rd_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              uart_read_req;
  logic [ADDR_W-1:0] uart_read_addr;
  logic              uart_read_ack;
  logic [DATA_W-1:0] status_bus_lock;
  logic              uart_read_err;

  modport master (
    output uart_read_req, uart_read_addr,
    input  uart_read_ack, status_bus_lock, uart_read_err
  );

  modport slave (
    input  uart_read_req, uart_read_addr,
    output uart_read_ack, status_bus_lock, uart_read_err
  );
endinterface

// File: rtl/uart_status_rd_bridge.sv
// Toggle-handshake status readback bridge: UART-domain read requests select one of NUM_REGS words.
// Optional coherent-snapshot shadow is built when STATUS_SNAPSHOT_EN is defined.
module uart_status_rd_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 101,
  parameter int BASE_ADDR   = 'h80,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       core_clk,
  input  logic                       core_rst,
  uart_status_rd_bridge_if.slave     rd,
  input  logic [NUM_REGS*DATA_W-1:0] status_bus_flat,
  output logic [7:0]                 rd_overrun_cnt,
  output logic                       rd_busy
);

  localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] NUM_X  = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SEL, LOAD, ACK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   req_edge;
  logic                   pending;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W:0]        idx;
  logic                   in_range;
  logic [DATA_W-1:0]      live_word;
  logic [DATA_W-1:0]      sel_word;
  logic [DATA_W-1:0]      data_q;
  logic                   err_q;

  assign req_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign idx      = {1'b0, addr_q} - BASE_X;
  assign in_range = ({1'b0, addr_q} >= BASE_X) && (idx < NUM_X);
  assign rd_busy  = (state != IDLE);

  always_comb begin
    live_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == (ADDR_W+1)'(i)) live_word = status_bus_flat[i*DATA_W +: DATA_W];
  end

`ifdef STATUS_SNAPSHOT_EN
  logic [NUM_REGS-1:0][DATA_W-1:0] shadow;
  logic [DATA_W-1:0]               shadow_word;

  always_comb begin
    shadow_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == (ADDR_W+1)'(i)) shadow_word = shadow[i];
  end

  // A read of word 0 is the capture trigger and itself returns live data.
  assign sel_word = (idx == '0) ? live_word : shadow_word;
`else
  assign sel_word = live_word;
`endif

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rd.uart_read_req};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state              <= IDLE;
      pending            <= 1'b0;
      addr_q             <= '0;
      data_q             <= '0;
      err_q              <= 1'b0;
      rd_overrun_cnt     <= '0;
      rd.uart_read_ack   <= 1'b0;
      rd.status_bus_lock <= '0;
      rd.uart_read_err   <= 1'b0;
`ifdef STATUS_SNAPSHOT_EN
      shadow             <= '0;
`endif
    end else begin
      // Accept immediately in IDLE; while busy, one request may queue, further ones are dropped.
      if (state == IDLE) begin
        if (req_edge || pending) begin
          addr_q  <= rd.uart_read_addr;
          pending <= req_edge && pending;
          state   <= SEL;
        end
      end else if (req_edge) begin
        if (!pending)                     pending        <= 1'b1;
        else if (rd_overrun_cnt != 8'hFF) rd_overrun_cnt <= rd_overrun_cnt + 8'd1;
      end

      case (state)
        SEL: begin
          data_q <= in_range ? sel_word : '0;
          err_q  <= ~in_range;
`ifdef STATUS_SNAPSHOT_EN
          if (in_range && idx == '0) shadow <= status_bus_flat;
`endif
          state  <= LOAD;
        end
        LOAD: begin
          rd.status_bus_lock <= data_q;
          rd.uart_read_err   <= err_q;
          state              <= ACK;
        end
        ACK: begin
          rd.uart_read_ack <= ~rd.uart_read_ack;
          state            <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_rd_bridge.sv
// Directed bench for uart_status_rd_bridge: vector table of single reads plus
// back-to-back/overrun, mid-read reset and (with STATUS_SNAPSHOT_EN) snapshot sequences.
module tb_uart_status_rd_bridge;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NUM_REGS = 101;

`ifdef STATUS_SNAPSHOT_EN
  localparam logic [7:0] BB_ADDR = 8'h80;
  localparam int         BB_IDX  = 0;
`else
  localparam logic [7:0] BB_ADDR = 8'h85;
  localparam int         BB_IDX  = 5;
`endif

  logic                       core_clk = 1'b0;
  logic                       core_rst;
  logic [NUM_REGS*DATA_W-1:0] flat;
  logic [7:0]                 cnt;
  logic                       busy;

  uart_status_rd_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  uart_status_rd_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .BASE_ADDR('h80), .SYNC_STAGES(2)
  ) dut (
    .core_clk       (core_clk),
    .core_rst       (core_rst),
    .rd             (bus.slave),
    .status_bus_flat(flat),
    .rd_overrun_cnt (cnt),
    .rd_busy        (busy)
  );

  always #5 core_clk = ~core_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        exp_ack;
  logic [31:0] exp_lock;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t vecs[9];

  task check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task set_word(input int i, input logic [31:0] v);
    flat[i*DATA_W +: DATA_W] = v;
  endtask

  // One read; edge 1 is the first posedge after the toggle is driven.
  task do_read(input logic [7:0] a, input logic [31:0] ed, input logic ee, input string nm);
    @(negedge core_clk);
    bus.uart_read_addr = a;
    bus.uart_read_req  = ~bus.uart_read_req;
    for (int k = 1; k <= 6; k++) begin
      @(posedge core_clk); #1;
      if (k == 4) check({nm, " lock_hold"}, bus.status_bus_lock, exp_lock);
      if (k == 5) begin
        check({nm, " lock"}, bus.status_bus_lock, ed);
        check({nm, " err"}, 32'(bus.uart_read_err), 32'(ee));
        check({nm, " ack_early"}, 32'(bus.uart_read_ack), 32'(exp_ack));
        exp_lock = ed;
      end
      if (k == 6) begin
        exp_ack = ~exp_ack;
        check({nm, " ack"}, 32'(bus.uart_read_ack), 32'(exp_ack));
        check({nm, " busy"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    core_rst = 1'b1;
    bus.uart_read_req = 1'b0;
    bus.uart_read_addr = '0;
    for (int i = 0; i < NUM_REGS; i++) set_word(i, 32'(i));
    set_word(5, 32'hDEADBEEF);
    exp_ack = 1'b0;
    exp_lock = '0;

    vecs[0] = '{8'h80, 32'h0000_0000, 1'b0};
    vecs[1] = '{8'h85, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{8'h7F, 32'h0000_0000, 1'b1};
    vecs[3] = '{8'hE5, 32'h0000_0000, 1'b1};
    vecs[4] = '{8'hE4, 32'h0000_0064, 1'b0};
    vecs[5] = '{8'h81, 32'h0000_0001, 1'b0};
    vecs[6] = '{8'hC0, 32'h0000_0040, 1'b0};
    vecs[7] = '{8'hFF, 32'h0000_0000, 1'b1};
    vecs[8] = '{8'h00, 32'h0000_0000, 1'b1};

    repeat (2) @(posedge core_clk);
    #1;
    check("rst ack", 32'(bus.uart_read_ack), 32'd0);
    check("rst lock", bus.status_bus_lock, 32'd0);
    check("rst err", 32'(bus.uart_read_err), 32'd0);
    check("rst cnt", 32'(cnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge core_clk);
    core_rst = 1'b0;

    for (int v = 0; v < 9; v++)
      do_read(vecs[v].addr, vecs[v].data, vecs[v].err, $sformatf("vec%0d", v));

    // Back-to-back pair plus a third toggle while one is already pending.
    set_word(BB_IDX, 32'hDEADBEEF);
    @(negedge core_clk);
    bus.uart_read_addr = BB_ADDR;
    bus.uart_read_req = ~bus.uart_read_req;
    @(posedge core_clk);
    @(negedge core_clk) bus.uart_read_req = ~bus.uart_read_req;
    @(posedge core_clk);
    @(negedge core_clk) bus.uart_read_req = ~bus.uart_read_req;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk) set_word(BB_IDX, 32'h12345678);
    @(posedge core_clk); #1;
    check("b2b first lock", bus.status_bus_lock, 32'hDEADBEEF);
    @(posedge core_clk); #1;
    exp_ack = ~exp_ack;
    check("b2b first ack", 32'(bus.uart_read_ack), 32'(exp_ack));
    repeat (3) @(posedge core_clk);
    #1;
    check("b2b second lock", bus.status_bus_lock, 32'h12345678);
    @(posedge core_clk); #1;
    exp_ack = ~exp_ack;
    check("b2b second ack", 32'(bus.uart_read_ack), 32'(exp_ack));
    repeat (12) @(posedge core_clk);
    #1;
    check("b2b no third ack", 32'(bus.uart_read_ack), 32'(exp_ack));
    check("b2b idle", 32'(busy), 32'd0);
    check("overrun cnt", 32'(cnt), 32'd1);
    set_word(BB_IDX, (BB_IDX == 5) ? 32'hDEADBEEF : 32'h0);

    // Reset while the read sits in LOAD.
    @(negedge core_clk);
    bus.uart_read_addr = 8'h85;
    bus.uart_read_req = ~bus.uart_read_req;
    repeat (4) @(posedge core_clk);
    #1;
    check("pre-rst busy", 32'(busy), 32'd1);
    core_rst = 1'b1;
    #1;
    check("midrst ack", 32'(bus.uart_read_ack), 32'd0);
    check("midrst lock", bus.status_bus_lock, 32'd0);
    check("midrst err", 32'(bus.uart_read_err), 32'd0);
    check("midrst cnt", 32'(cnt), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    bus.uart_read_req = 1'b0;
    exp_ack = 1'b0;
    exp_lock = '0;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk) core_rst = 1'b0;
    repeat (10) @(posedge core_clk);
    #1;
    check("post-rst ack quiet", 32'(bus.uart_read_ack), 32'd0);
    check("post-rst busy", 32'(busy), 32'd0);
`ifdef STATUS_SNAPSHOT_EN
    do_read(8'h80, 32'h0, 1'b0, "post-rst capture");
`endif
    do_read(8'h85, 32'hDEADBEEF, 1'b0, "post-rst read");

`ifdef STATUS_SNAPSHOT_EN
    set_word(3, 32'd1);
    do_read(8'h80, 32'h0, 1'b0, "snap cap1");
    set_word(3, 32'd2);
    do_read(8'h83, 32'd1, 1'b0, "snap old");
    do_read(8'h80, 32'h0, 1'b0, "snap cap2");
    do_read(8'h83, 32'd2, 1'b0, "snap new");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
